tournament_gshare_predictor: RTL and testbench

- Parametrised successor to the single-chooser tournament predictor.
- Combines a PC-indexed BTB with local 2^IDX_W counters, a gshare table (PC xor global history), and a per-PC chooser table instead of one global chooser.
- Sits beside IF for combinational lookup. Trains from EX using prediction metadata that the pipeline carries down with each instruction.
- Conditional vs unconditional control flow is distinguished: jumps always predict taken on a BTB hit.

---
 rtl/tournament_gshare_predictor.sv | 158 +++++++++++++++
 tb/tb_tournament_gshare_predictor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tournament_gshare_predictor
// Brief    : BTB + local/gshare tournament branch predictor, per-PC chooser.
//            Optional performance counters enabled by macro BP_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tournament_gshare_predictor #(
    parameter int IDX_W   = 8,
    parameter int GHIST_W = 8,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        if_pc,
    output logic               if_pred_taken,
    output logic [31:0]        if_pred_target,
    output logic [GHIST_W-1:0] if_ghist,
    input  logic               ex_valid,
    input  logic               ex_is_cf,
    input  logic               ex_is_cond,
    input  logic [31:0]        ex_pc,
    input  logic               ex_taken,
    input  logic [31:0]        ex_target,
    input  logic [GHIST_W-1:0] ex_ghist,
    input  logic               ex_pred_taken,
    input  logic [31:0]        ex_pred_target,
    output logic               mispredict,
    output logic [31:0]        perf_cf_cnt,
    output logic [31:0]        perf_mispred_cnt
);

    localparam int c_n_idx = 1 << IDX_W;
    localparam int c_n_ghr = 1 << GHIST_W;
    localparam int c_tag_w = 30 - IDX_W;
    localparam logic [CTR_W-1:0] c_ctr_max = '1;
    localparam logic [CTR_W-1:0] c_one     = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0] c_weak_t  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] c_weak_nt = {1'b0, {(CTR_W-1){1'b1}}};

    logic [c_n_idx-1:0] r_btb_valid;
    logic [c_n_idx-1:0] r_btb_uncond;
    logic [c_tag_w-1:0] r_btb_tag    [c_n_idx];
    logic [31:0]        r_btb_target [c_n_idx];
    logic [CTR_W-1:0]   r_local      [c_n_idx];
    logic [CTR_W-1:0]   r_chooser    [c_n_idx];
    logic [CTR_W-1:0]   r_gshare     [c_n_ghr];
    logic [GHIST_W-1:0] r_ghist;

    function automatic logic [CTR_W-1:0] f_sat(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (c == c_ctr_max) ? c : c + c_one;
        else
            return (c == '0) ? c : c - c_one;
    endfunction

    // Fetch-side lookup
    logic [IDX_W-1:0]   w_if_idx;
    logic [c_tag_w-1:0] w_if_tag;
    logic [GHIST_W-1:0] w_if_gidx;
    logic               w_if_hit;
    logic               w_if_dir;

    assign w_if_idx  = if_pc[IDX_W+1:2];
    assign w_if_tag  = if_pc[31:IDX_W+2];
    assign w_if_gidx = if_pc[GHIST_W+1:2] ^ r_ghist;
    assign w_if_hit  = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
    assign w_if_dir  = r_chooser[w_if_idx][CTR_W-1] ? r_gshare[w_if_gidx][CTR_W-1]
                                                    : r_local[w_if_idx][CTR_W-1];

    assign if_pred_taken  = w_if_hit && (r_btb_uncond[w_if_idx] || w_if_dir);
    assign if_pred_target = w_if_hit ? r_btb_target[w_if_idx] : 32'd0;
    assign if_ghist       = r_ghist;

    // Execute-side resolution, all reads are pre-write values
    logic               w_ex_upd;
    logic               w_ex_cond_upd;
    logic [IDX_W-1:0]   w_ex_idx;
    logic [c_tag_w-1:0] w_ex_tag;
    logic [GHIST_W-1:0] w_ex_gidx;
    logic               w_ex_hit;
    logic [CTR_W-1:0]   w_loc_old;
    logic [CTR_W-1:0]   w_gsh_old;
    logic               w_unused_pc_lsbs;

    assign w_ex_upd      = ex_valid && ex_is_cf;
    assign w_ex_cond_upd = w_ex_upd && ex_is_cond;
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign w_ex_tag      = ex_pc[31:IDX_W+2];
    assign w_ex_gidx     = ex_pc[GHIST_W+1:2] ^ ex_ghist;
    assign w_ex_hit      = r_btb_valid[w_ex_idx] && (r_btb_tag[w_ex_idx] == w_ex_tag);
    assign w_loc_old     = r_local[w_ex_idx];
    assign w_gsh_old     = r_gshare[w_ex_gidx];
    assign w_unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign mispredict = w_ex_upd &&
                        ((ex_pred_taken != ex_taken) ||
                         (ex_taken && (ex_pred_target != ex_target)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btb_valid  <= '0;
            r_btb_uncond <= '0;
            r_ghist      <= '0;
            for (int i = 0; i < c_n_idx; i++) begin
                r_local[i]   <= c_weak_nt;
                r_chooser[i] <= c_weak_nt;
            end
            for (int j = 0; j < c_n_ghr; j++) begin
                r_gshare[j] <= c_weak_nt;
            end
        end else begin
            if (w_ex_upd && ex_taken) begin
                r_btb_valid[w_ex_idx]  <= 1'b1;
                r_btb_uncond[w_ex_idx] <= !ex_is_cond;
                r_btb_tag[w_ex_idx]    <= w_ex_tag;
                r_btb_target[w_ex_idx] <= ex_target;
            end
            if (w_ex_cond_upd) begin
                // A taken branch that misses allocates with a fresh weakly-taken counter
                if (w_ex_hit)
                    r_local[w_ex_idx] <= f_sat(w_loc_old, ex_taken);
                else if (ex_taken)
                    r_local[w_ex_idx] <= c_weak_t;
                r_gshare[w_ex_gidx] <= f_sat(w_gsh_old, ex_taken);
                if (w_loc_old[CTR_W-1] != w_gsh_old[CTR_W-1])
                    r_chooser[w_ex_idx] <= f_sat(r_chooser[w_ex_idx],
                                                 w_gsh_old[CTR_W-1] == ex_taken);
                r_ghist <= {r_ghist[GHIST_W-2:0], ex_taken};
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_perf_cf;
    logic [31:0] r_perf_mp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cf <= '0;
            r_perf_mp <= '0;
        end else begin
            if (w_ex_upd && (r_perf_cf != 32'hFFFF_FFFF))
                r_perf_cf <= r_perf_cf + 32'd1;
            if (mispredict && (r_perf_mp != 32'hFFFF_FFFF))
                r_perf_mp <= r_perf_mp + 32'd1;
        end
    end

    assign perf_cf_cnt      = r_perf_cf;
    assign perf_mispred_cnt = r_perf_mp;
`else
    assign perf_cf_cnt      = 32'd0;
    assign perf_mispred_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tournament_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_gshare_predictor
// Brief    : Vector table, directed sequences and random run vs. a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tournament_gshare_predictor;

    localparam int IDX_W   = 8;
    localparam int GHIST_W = 8;
    localparam int CTR_W   = 2;
    localparam int NI      = 1 << IDX_W;
    localparam int NG      = 1 << GHIST_W;
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int HALF    = 1 << (CTR_W - 1);
`ifdef BP_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        if_pc;
    logic               if_pred_taken;
    logic [31:0]        if_pred_target;
    logic [GHIST_W-1:0] if_ghist;
    logic               ex_valid, ex_is_cf, ex_is_cond, ex_taken, ex_pred_taken;
    logic [31:0]        ex_pc, ex_target, ex_pred_target;
    logic [GHIST_W-1:0] ex_ghist;
    logic               mispredict;
    logic [31:0]        perf_cf_cnt, perf_mispred_cnt;

    always #5 clk = ~clk;

    tournament_gshare_predictor #(.IDX_W(IDX_W), .GHIST_W(GHIST_W), .CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .if_ghist(if_ghist), .ex_valid(ex_valid),
        .ex_is_cf(ex_is_cf), .ex_is_cond(ex_is_cond), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_ghist(ex_ghist), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .mispredict(mispredict),
        .perf_cf_cnt(perf_cf_cnt), .perf_mispred_cnt(perf_mispred_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (integer arithmetic) ----------------
    bit          m_valid [NI];
    int unsigned m_tag   [NI];
    logic [31:0] m_tgt   [NI];
    bit          m_unc   [NI];
    int          m_loc   [NI];
    int          m_cho   [NI];
    int          m_gsh   [NG];
    int unsigned m_hist;
    longint      m_pcf, m_pmp;

    function automatic void m_reset();
        for (int i = 0; i < NI; i++) begin
            m_valid[i] = 1'b0; m_loc[i] = HALF - 1; m_cho[i] = HALF - 1;
        end
        for (int i = 0; i < NG; i++) m_gsh[i] = HALF - 1;
        m_hist = 0; m_pcf = 0; m_pmp = 0;
    endfunction

    function automatic int unsigned f_idx(input logic [31:0] pc);
        return (pc >> 2) % NI;
    endfunction
    function automatic int unsigned f_tag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction
    function automatic int unsigned f_gidx(input logic [31:0] pc, input int unsigned h);
        return ((pc >> 2) ^ h) % NG;
    endfunction
    function automatic int bump(input int c, input bit up);
        if (up) return (c < CMAX) ? c + 1 : c;
        return (c > 0) ? c - 1 : c;
    endfunction
    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
    endfunction
    function automatic bit m_pred(input logic [31:0] pc);
        int ctr;
        if (!m_hit(pc)) return 1'b0;
        if (m_unc[f_idx(pc)]) return 1'b1;
        ctr = (m_cho[f_idx(pc)] >= HALF) ? m_gsh[f_gidx(pc, m_hist)] : m_loc[f_idx(pc)];
        return ctr >= HALF;
    endfunction
    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[f_idx(pc)] : 32'd0;
    endfunction
    function automatic bit m_mispred();
        return ex_valid && ex_is_cf &&
               ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
    endfunction

    function automatic void m_update();
        int unsigned i, g;
        int lo, go;
        bit hit;
        if (rst) begin m_reset(); return; end
        if (!(ex_valid && ex_is_cf)) return;
        if (m_pcf < 64'hFFFF_FFFF) m_pcf++;
        if (m_mispred() && m_pmp < 64'hFFFF_FFFF) m_pmp++;
        i = f_idx(ex_pc); g = f_gidx(ex_pc, ex_ghist);
        hit = m_hit(ex_pc); lo = m_loc[i]; go = m_gsh[g];
        if (ex_is_cond) begin
            if (hit) m_loc[i] = bump(lo, ex_taken);
            else if (ex_taken) m_loc[i] = HALF;
            m_gsh[g] = bump(go, ex_taken);
            if ((lo >= HALF) != (go >= HALF)) m_cho[i] = bump(m_cho[i], (go >= HALF) == ex_taken);
            m_hist = ((m_hist << 1) | ex_taken) % NG;
        end
        if (ex_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = f_tag(ex_pc); m_tgt[i] = ex_target; m_unc[i] = !ex_is_cond;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] ipc, input bit v, input bit cf, input bit cond,
                         input logic [31:0] epc, input bit t, input logic [31:0] tgt,
                         input logic [GHIST_W-1:0] gh, input bit pt, input logic [31:0] ptgt);
        if_pc = ipc; ex_valid = v; ex_is_cf = cf; ex_is_cond = cond; ex_pc = epc;
        ex_taken = t; ex_target = tgt; ex_ghist = gh; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ex_valid = 1'b0;
        finish_cycle();
        rst = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pt"},  32'(if_pred_taken),  32'(m_pred(if_pc)));
        check({tag, ".tgt"}, if_pred_target,       m_ptgt(if_pc));
        check({tag, ".gh"},  32'(if_ghist),       32'(m_hist));
        check({tag, ".mp"},  32'(mispredict),     32'(m_mispred()));
        check({tag, ".pcf"}, perf_cf_cnt,         PERF_ON ? 32'(m_pcf) : 32'd0);
        check({tag, ".pmp"}, perf_mispred_cnt,    PERF_ON ? 32'(m_pmp) : 32'd0);
    endtask

    // drive an EX branch whose carried prediction is the model's own lookup
    task automatic model_branch(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
        drive(pc, 1'b1, 1'b1, 1'b1, pc, t, tgt, GHIST_W'(m_hist), m_pred(pc), m_ptgt(pc));
    endtask

    typedef struct {
        logic [31:0] ipc; bit v; bit cf; bit cond; logic [31:0] epc; bit t;
        logic [31:0] tgt; logic [GHIST_W-1:0] gh; bit ept; logic [31:0] eptgt;
        bit x_pt; logic [31:0] x_tgt; logic [GHIST_W-1:0] x_gh; bit x_mp;
    } vec_t;

    vec_t tbl [10];

    logic [31:0] pool [8];
    bit          kind_cond [8];
    int          late_mp;

    initial begin
        tbl[0] = '{32'h60,   1'b1,1'b1,1'b1, 32'h60,   1'b1, 32'h100,  8'h00, 1'b0, 32'h0,   1'b0, 32'h0,    8'h00, 1'b1};
        tbl[1] = '{32'h60,   1'b0,1'b0,1'b0, 32'h0,    1'b0, 32'h0,    8'h00, 1'b0, 32'h0,   1'b1, 32'h100,  8'h01, 1'b0};
        tbl[2] = '{32'h80,   1'b1,1'b1,1'b0, 32'h80,   1'b1, 32'h200,  8'h01, 1'b0, 32'h0,   1'b0, 32'h0,    8'h01, 1'b1};
        tbl[3] = '{32'h80,   1'b1,1'b1,1'b0, 32'h80,   1'b1, 32'h200,  8'h01, 1'b1, 32'h200, 1'b1, 32'h200,  8'h01, 1'b0};
        tbl[4] = '{32'h80,   1'b0,1'b1,1'b1, 32'h90,   1'b1, 32'h999,  8'h01, 1'b0, 32'h0,   1'b1, 32'h200,  8'h01, 1'b0};
        tbl[5] = '{32'h90,   1'b0,1'b0,1'b0, 32'h0,    1'b0, 32'h0,    8'h00, 1'b0, 32'h0,   1'b0, 32'h0,    8'h01, 1'b0};
        tbl[6] = '{32'h1000, 1'b1,1'b1,1'b1, 32'h1000, 1'b1, 32'h2000, 8'h01, 1'b0, 32'h0,   1'b0, 32'h0,    8'h01, 1'b1};
        tbl[7] = '{32'h1000, 1'b1,1'b1,1'b1, 32'h2400, 1'b1, 32'h3000, 8'h03, 1'b0, 32'h0,   1'b1, 32'h2000, 8'h03, 1'b1};
        tbl[8] = '{32'h1000, 1'b0,1'b0,1'b0, 32'h0,    1'b0, 32'h0,    8'h00, 1'b0, 32'h0,   1'b0, 32'h0,    8'h07, 1'b0};
        tbl[9] = '{32'h2400, 1'b0,1'b0,1'b0, 32'h0,    1'b0, 32'h0,    8'h00, 1'b0, 32'h0,   1'b1, 32'h3000, 8'h07, 1'b0};

        pool = '{32'h40, 32'h60, 32'h1000, 32'h2400, 32'h80, 32'h500, 32'h440, 32'h84};
        kind_cond = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst = 1'b0;

        // vector table: allocation, jal, stall, BTB replacement
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].ipc, tbl[i].v, tbl[i].cf, tbl[i].cond, tbl[i].epc, tbl[i].t,
                  tbl[i].tgt, tbl[i].gh, tbl[i].ept, tbl[i].eptgt);
            @(negedge clk);
            check($sformatf("vec%0d.pt", i),  32'(if_pred_taken), 32'(tbl[i].x_pt));
            check($sformatf("vec%0d.tgt", i), if_pred_target,      tbl[i].x_tgt);
            check($sformatf("vec%0d.gh", i),  32'(if_ghist),      32'(tbl[i].x_gh));
            check($sformatf("vec%0d.mp", i),  32'(mispredict),    32'(tbl[i].x_mp));
            finish_cycle();
        end

        // reset asserted together with a valid update: the update is dropped
        do_reset();
        drive(32'h60, 1'b1, 1'b1, 1'b1, 32'h60, 1'b1, 32'h100, '0, 1'b0, 32'h0);
        rst = 1'b1;
        finish_cycle();
        rst = 1'b0;
        drive(32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst_wins.pt",  32'(if_pred_taken), 32'd0);
        check("rst_wins.tgt", if_pred_target,      32'd0);
        check("rst_wins.gh",  32'(if_ghist),      32'd0);
        finish_cycle();

        // perf counters: three control-flow ops, one mispredicted
        do_reset();
        drive(32'h0, 1'b1, 1'b1, 1'b1, 32'h60, 1'b1, 32'h100, '0, 1'b0, 32'h0);
        finish_cycle();
        drive(32'h0, 1'b1, 1'b1, 1'b1, 32'h60, 1'b1, 32'h100, 8'h01, 1'b1, 32'h100);
        finish_cycle();
        drive(32'h0, 1'b1, 1'b1, 1'b0, 32'h80, 1'b1, 32'h200, 8'h03, 1'b1, 32'h200);
        finish_cycle();
        ex_valid = 1'b0;
        check("perf.cf", perf_cf_cnt,      PERF_ON ? 32'd3 : 32'd0);
        check("perf.mp", perf_mispred_cnt, PERF_ON ? 32'd1 : 32'd0);

        // counter walk: 4 taken then 4 not-taken
        do_reset();
        for (int i = 0; i < 8; i++) begin
            model_branch(32'h500, i < 4, 32'h700);
            @(negedge clk);
            check_model($sformatf("walk%0d", i));
            if (i == 5) check("walk.before_flip", 32'(if_pred_taken), 32'd1);
            if (i == 6) check("walk.after_flip",  32'(if_pred_taken), 32'd0);
            finish_cycle();
        end

        // alternating branch: the gshare side must take over
        do_reset();
        late_mp = 0;
        for (int i = 0; i < 32; i++) begin
            model_branch(32'h40, (i % 2) == 0, 32'h300);
            @(negedge clk);
            check_model($sformatf("alt%0d", i));
            if (i >= 16 && mispredict) late_mp++;
            finish_cycle();
        end
        check("alt.late_mispredicts", 32'(late_mp), 32'd0);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int k;
            bit v, cf, t, pt;
            logic [31:0] tgt, ptgt;
            logic [GHIST_W-1:0] gh;
            k   = int'($urandom_range(0, 7));
            v   = ($urandom_range(0, 3) != 0);
            cf  = ($urandom_range(0, 5) != 0);
            t   = kind_cond[k] ? ($urandom_range(0, 1) == 1) : 1'b1;
            tgt = ($urandom_range(0, 7) == 0) ? pool[k] + 32'h200 : pool[k] + 32'h100;
            gh  = ($urandom_range(0, 3) == 0) ? GHIST_W'($urandom) : GHIST_W'(m_hist);
            if ($urandom_range(0, 4) != 0) begin
                pt = m_pred(pool[k]); ptgt = m_ptgt(pool[k]);
            end else begin
                pt = ($urandom_range(0, 1) == 1); ptgt = $urandom;
            end
            drive(pool[$urandom_range(0, 7)], v, cf, kind_cond[k], pool[k], t, tgt, gh, pt, ptgt);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d", n));
            finish_cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
